// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that feeds byte streams from NUM_REQ requesters into one UART transmitter.
// A packet holds the grant until its last byte, or until it has sat idle for TIMEOUT_CYCLES.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1200000
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    input  logic [8*NUM_REQ-1:0]   req_data_i,
    input  logic [NUM_REQ-1:0]     req_last_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    input  logic                   tx_busy_i,
    output logic                   tx_write_o,
    output logic [7:0]             tx_data_o,
    output logic [NUM_REQ-1:0]     grant_o,
    output logic                   timeout_o
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {ARB, ISSUE, GAP} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   grant_q, grant_d;
    logic [IW-1:0]   last_grant_q, last_grant_d;
    logic            last_q, last_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            timeout_q, timeout_d;

    logic            valid_g;
    logic            accept;
    logic            found;
    logic [IW-1:0]   pick;
    int              idx;

    // Search upward from the requester after the previous owner, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = last_grant_q;
        idx   = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = int'(last_grant_q) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req_valid_i[idx]) begin
                found = 1'b1;
                pick  = IW'(idx);
            end
        end
    end

    assign valid_g = req_valid_i[grant_q];
    // Gated by reset so a lock abandoned by reset never emits a byte in the reset cycle.
    assign accept  = (state_q == ISSUE) && valid_g && !tx_busy_i && !reset;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        last_d       = last_q;
        cnt_d        = '0;
        timeout_d    = 1'b0;
        case (state_q)
            ARB: begin
                if (found) begin
                    grant_d      = pick;
                    last_grant_d = pick;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                if (accept) begin
                    last_d  = req_last_i[grant_q];
                    state_d = GAP;
                end else if (!valid_g) begin
                    if (cnt_q >= CNT_LAST) begin
                        timeout_d = 1'b1;
                        state_d   = ARB;
                    end else begin
                        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            GAP: begin
                state_d = last_q ? ARB : ISSUE;
            end
            default: state_d = ARB;
        endcase
    end

    always_comb begin
        req_ready_o = '0;
        grant_o     = '0;
        if (accept) req_ready_o[grant_q] = 1'b1;
        if (state_q != ARB) grant_o[grant_q] = 1'b1;
    end

    assign tx_write_o = accept;
    assign tx_data_o  = req_data_i[{grant_q, 3'b000} +: 8];
    assign timeout_o  = timeout_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ARB;
            grant_q      <= '0;
            last_grant_q <= IW'(NUM_REQ - 1);
            last_q       <= 1'b0;
            cnt_q        <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            last_q       <= last_d;
            cnt_q        <= cnt_d;
            timeout_q    <= timeout_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester queues drive the inputs, a monitor checks each write.
module tb_uart_tx_arbiter;

    localparam int N = 4;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [N-1:0]     req_valid_i;
    logic [8*N-1:0]   req_data_i;
    logic [N-1:0]     req_last_i;
    logic [N-1:0]     req_ready_o;
    logic             tx_busy_i;
    logic             tx_write_o;
    logic [7:0]       tx_data_o;
    logic [N-1:0]     grant_o;
    logic             timeout_o;

    uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(16)) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid_i (req_valid_i),
        .req_data_i  (req_data_i),
        .req_last_i  (req_last_i),
        .req_ready_o (req_ready_o),
        .tx_busy_i   (tx_busy_i),
        .tx_write_o  (tx_write_o),
        .tx_data_o   (tx_data_o),
        .grant_o     (grant_o),
        .timeout_o   (timeout_o)
    );

    always #5 clock = ~clock;

    typedef struct { logic [7:0] d; logic l; } item_t;
    typedef struct { int r; logic [7:0] d; } exp_t;

    item_t rq[N][$];
    exp_t  exp_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wr_count = 0;
    int last_wr_cyc = -10;
    int to_count = 0;
    int to_cyc = 0;
    logic [N-1:0] to_grant = '0;
    bit busy_mode = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic put(input int r, input logic [7:0] d, input logic l);
        item_t it;
        it.d = d;
        it.l = l;
        rq[r].push_back(it);
    endtask

    task automatic expect_byte(input int r, input logic [7:0] d);
        exp_t e;
        e.r = r;
        e.d = d;
        exp_q.push_back(e);
    endtask

    function automatic bit all_idle();
        bit idle;
        idle = (exp_q.size() == 0);
        for (int i = 0; i < N; i++) if (rq[i].size() != 0) idle = 1'b0;
        return idle;
    endfunction

    task automatic wait_drain(input string name, input int bound);
        int n;
        bit done;
        n = 0;
        done = all_idle();
        while (!done && n < bound) begin
            @(negedge clock);
            n++;
            done = all_idle();
        end
        chk(name, {31'd0, done}, 32'd1);
    endtask

    // Requester and transmitter models: handshake sampled mid-cycle, inputs updated just after the edge.
    initial begin
        bit fire[N];
        bit wrote;
        int busy_cnt;
        busy_cnt    = 0;
        req_valid_i = '0;
        req_data_i  = '0;
        req_last_i  = '0;
        tx_busy_i   = 1'b0;
        forever begin
            @(negedge clock);
            for (int i = 0; i < N; i++) fire[i] = req_valid_i[i] && req_ready_o[i];
            wrote = tx_write_o;
            @(posedge clock);
            #1;
            for (int i = 0; i < N; i++) if (fire[i]) void'(rq[i].pop_front());
            if (wrote && busy_mode) busy_cnt = 20;
            else if (busy_cnt > 0) busy_cnt--;
            tx_busy_i = (busy_cnt > 0);
            for (int i = 0; i < N; i++) begin
                req_valid_i[i] = (rq[i].size() != 0);
                req_data_i[8*i +: 8] = (rq[i].size() != 0) ? rq[i][0].d : 8'h00;
                req_last_i[i] = (rq[i].size() != 0) ? rq[i][0].l : 1'b0;
            end
        end
    end

    // Monitor: every write is matched against the next expected (requester, byte) pair.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (!reset && (req_ready_o & ~grant_o) != '0)
                chk("ready_outside_grant", 32'(req_ready_o & ~grant_o), 32'd0);
            if (tx_write_o) begin
                wr_count++;
                chk("write_while_busy", {31'd0, tx_busy_i}, 32'd0);
                if (cyc - last_wr_cyc < 2) chk("write_spacing", cyc - last_wr_cyc, 32'd2);
                last_wr_cyc = cyc;
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", {24'd0, tx_data_o}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("tx_data", {24'd0, tx_data_o}, {24'd0, e.d});
                    chk("write_grant", {28'd0, grant_o}, 32'd1 << e.r);
                end
            end
            if (timeout_o) begin
                to_count++;
                to_cyc   = cyc;
                to_grant = grant_o;
            end
        end
    end

    initial begin
        int t_wr;
        int to_before;
        int wr_before;
        int n;

        // Reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_grant", {28'd0, grant_o}, 32'd0);
        chk("rst_write", {31'd0, tx_write_o}, 32'd0);
        chk("rst_ready", {28'd0, req_ready_o}, 32'd0);
        chk("rst_timeout", {31'd0, timeout_o}, 32'd0);
        @(posedge clock); #2;
        reset = 1'b0;
        repeat (2) @(posedge clock);

        // Requesters 0 and 2 together: 0 wins, its packet finishes before 2
        #2;
        put(0, 8'h10, 1'b0); put(0, 8'h11, 1'b1); put(2, 8'h20, 1'b1);
        expect_byte(0, 8'h10); expect_byte(0, 8'h11); expect_byte(2, 8'h20);
        @(posedge clock); #2;
        @(negedge clock);
        chk("arb_cycle_grant", {28'd0, grant_o}, 32'd0);
        chk("arb_cycle_ready", {28'd0, req_ready_o}, 32'd0);
        @(negedge clock);
        chk("first_grant", {28'd0, grant_o}, 32'b0001);
        wait_drain("drain_two_req", 100);

        // Solo byte on 0 moves priority so requester 1 is next
        @(posedge clock); #2;
        put(0, 8'h05, 1'b1);
        expect_byte(0, 8'h05);
        wait_drain("drain_solo", 100);

        // Locked 3-byte packet from 1 while 3 waits
        @(posedge clock); #2;
        put(1, 8'h41, 1'b0); put(1, 8'h42, 1'b0); put(1, 8'h43, 1'b1); put(3, 8'h50, 1'b1);
        expect_byte(1, 8'h41); expect_byte(1, 8'h42); expect_byte(1, 8'h43); expect_byte(3, 8'h50);
        wait_drain("drain_locked", 100);

        // All four valid, single-byte packets: round-robin 0,1,2,3,0,1,2,3
        @(posedge clock); #2;
        for (int i = 0; i < N; i++) begin
            logic [7:0] b0;
            logic [7:0] b1;
            b0 = 8'(8'hA0 + 8'(i * 16));
            b1 = 8'(b0 + 8'h01);
            put(i, b0, 1'b1);
            put(i, b1, 1'b1);
        end
        for (int i = 0; i < N; i++) expect_byte(i, 8'(8'hA0 + 8'(i * 16)));
        for (int i = 0; i < N; i++) expect_byte(i, 8'(8'hA1 + 8'(i * 16)));
        wait_drain("drain_rr", 200);

        // Slow transmitter: 20 busy cycles after each write must not trigger a timeout
        to_before = to_count;
        wr_before = wr_count;
        busy_mode = 1'b1;
        @(posedge clock); #2;
        put(1, 8'h61, 1'b0); put(1, 8'h62, 1'b0); put(1, 8'h63, 1'b1);
        expect_byte(1, 8'h61); expect_byte(1, 8'h62); expect_byte(1, 8'h63);
        wait_drain("drain_busy", 300);
        busy_mode = 1'b0;
        repeat (25) @(negedge clock);
        chk("busy_no_timeout", to_count - to_before, 32'd0);
        chk("busy_write_count", wr_count - wr_before, 32'd3);

        // Idle lock: non-last byte then silence -> forced release
        to_before = to_count;
        @(posedge clock); #2;
        put(2, 8'h77, 1'b0);
        expect_byte(2, 8'h77);
        wait_drain("drain_timeout_byte", 100);
        t_wr = last_wr_cyc;
        repeat (30) @(negedge clock);
        chk("timeout_pulses", to_count - to_before, 32'd1);
        chk("timeout_delay", to_cyc - t_wr, 32'd18);
        chk("timeout_grant", {28'd0, to_grant}, 32'd0);
        chk("post_timeout_grant", {28'd0, grant_o}, 32'd0);

        // Reset during the GAP of a locked packet from requester 3
        @(posedge clock); #2;
        put(3, 8'h81, 1'b0); put(3, 8'h82, 1'b1); put(0, 8'h90, 1'b1);
        expect_byte(3, 8'h81); expect_byte(0, 8'h90); expect_byte(3, 8'h82);
        n = 0;
        @(negedge clock);
        while (!tx_write_o && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk("lock_write_seen", {31'd0, tx_write_o}, 32'd1);
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        chk("rst_cycle_write", {31'd0, tx_write_o}, 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        chk("after_rst_grant", {28'd0, grant_o}, 32'd0);
        chk("after_rst_write", {31'd0, tx_write_o}, 32'd0);
        @(negedge clock);
        chk("after_rst_priority", {28'd0, grant_o}, 32'b0001);
        wait_drain("drain_after_reset", 100);

        repeat (5) @(negedge clock);
        chk("leftover_expected", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d checks %0d errors", checks, errors);
        $fatal(1);
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of byte-stream requesters (2..8).
REQ-002 Parameter TIMEOUT_CYCLES, default 1200000, idle cycles in a locked packet before forced release (100 ms at 12 MHz).
REQ-003 clock  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid_i  input  NUM_REQ  per-requester byte-available flag.
REQ-006 req_data_i  input  8*NUM_REQ  per-requester byte; requester i occupies bits [8i+7:8i].
REQ-007 req_last_i  input  NUM_REQ  marks the presented byte as the final byte of its packet.
REQ-008 req_ready_o  output  NUM_REQ  per-requester accept strobe; byte consumed when valid and ready are both high.
REQ-009 tx_busy_i  input  1  busy flag from the downstream UART transmitter.
REQ-010 tx_write_o  output  1  one-cycle write strobe to the transmitter.
REQ-011 tx_data_o  output  8  byte to the transmitter; meaningful only while tx_write_o is high.
REQ-012 grant_o  output  NUM_REQ  one-hot owner of the transmitter; all-zero when unowned.
REQ-013 timeout_o  output  1  one-cycle pulse on forced release of a lock.

Function
REQ-014 State machine SHALL have exactly three states: ARB, ISSUE, GAP.
REQ-015 ARB: grant_o zero; if any req_valid_i bit is high, the first set bit searching upward from (last_grant+1) mod NUM_REQ, wrapping, SHALL be registered as grant; next state ISSUE. Otherwise stay in ARB.
REQ-016 last_grant SHALL update to the new grant index on every ARB->ISSUE transition.
REQ-017 ISSUE with grant g: when req_valid_i[g]=1 and tx_busy_i=0, req_ready_o[g], tx_write_o and tx_data_o=req_data_i[g] SHALL be driven combinationally in the same cycle; next state GAP.
REQ-018 req_ready_o SHALL be zero for every non-granted requester, and zero in ARB and GAP.
REQ-019 GAP SHALL last exactly one cycle, ignoring tx_busy_i, to cover the transmitter's one-cycle busy latency.
REQ-020 From GAP: if the accepted byte had req_last_i[g]=1, next state ARB; otherwise ISSUE with grant unchanged (packet lock).
REQ-021 ISSUE SHALL hold while tx_busy_i=1 or req_valid_i[g]=0; no bytes from other requesters are accepted while locked.
REQ-022 Timeout counter SHALL count cycles in ISSUE with req_valid_i[g]=0; it SHALL clear on any accepted byte and on leaving ISSUE.
REQ-023 When the counter reaches TIMEOUT_CYCLES-1 and req_valid_i[g] is still 0, timeout_o SHALL pulse for one cycle and the next state SHALL be ARB.
REQ-024 Cycles where tx_busy_i=1 and req_valid_i[g]=1 SHALL NOT advance the timeout counter.
REQ-025 Counter width SHALL be $clog2(TIMEOUT_CYCLES)+1 bits; it SHALL saturate and never wrap.
REQ-026 Minimum spacing between tx_write_o pulses SHALL be 2 cycles (ISSUE, GAP); throughput otherwise limited by tx_busy_i.
REQ-027 ARB->ISSUE latency SHALL be exactly one cycle; no byte is accepted in the ARB cycle.
REQ-028 Single requester continuously valid SHALL be re-granted after each packet (round-robin wraps back to it).

Reset
REQ-029 On reset: state ARB, grant_o 0, last_grant NUM_REQ-1 (so requester 0 has first priority), timeout counter 0, timeout_o 0, tx_write_o 0, req_ready_o 0.
REQ-030 Reset asserted mid-packet SHALL abandon the lock immediately, with no tx_write_o in the reset cycle or the cycle after it.

Verification
REQ-031 After reset, valid on req 0 and req 2 in the same cycle -> grant_o=4'b0001 next cycle; req 0's packet completes before grant_o=4'b0100.
REQ-032 Req 1 sends 3-byte packet 0x41,0x42,0x43 (last on 0x43) while req 3 stays valid -> tx_data_o exactly 41,42,43 with no req 3 byte interleaved, then grant_o=4'b1000.
REQ-033 tx_busy_i held high 20 cycles after each write with req valid -> exactly one tx_write_o per busy-low window; no timeout_o.
REQ-034 TIMEOUT_CYCLES=16, req 2 sends non-last byte then drops valid -> timeout_o pulses exactly 16 cycles after entering ISSUE idle; state ARB; grant_o=0.
REQ-035 All four requesters continuously valid, single-byte packets -> grants cycle 0,1,2,3,0 in order.
REQ-036 Reset pulsed during GAP of a locked packet -> grant_o=0 and tx_write_o=0 for the following cycle; requester 0 has next priority.
